fetch_unit: RTL and testbench

Instruction fetch sequencer on the producer side of the instruction-register load interface. It reads 16-bit instruction words from program memory through a ready-handshake, presents each word on `code` and pulses `iir` for exactly one cycle so the instruction register latches and decodes it. It then waits for the datapath to finish the instruction, applies any taken branch or the sequential increment to the program counter, and fetches again. It also handles halting and memory timeout.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads a word from program memory, strobes it into
// the instruction register, waits for execution, then advances or branches the pc.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_rdy,
  input  logic [15:0] mem_q,
  output logic [15:0] code,
  output logic        iir,
  input  logic        exec_done,
  input  logic        jmp_en,
  input  logic [15:0] jmp_addr,
  input  logic        halt,
  output logic [15:0] pc,
  output logic        busy,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  // Handshakes: memory word is taken in any FETCH cycle where mem_rdy=1; the
  // instruction retires in the first EXEC cycle with exec_done=1. Neither input
  // has any effect in other states.
  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] code_q, code_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic        iir_q, iir_d;
  logic        mem_rd_q, mem_rd_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    code_d  = code_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: state_d = halt ? S_HALTED : S_FETCH;
      S_FETCH: begin
        if (mem_rdy) begin
          code_d  = mem_q;
          wait_d  = 8'd0;
          state_d = S_LOAD;
        end else begin
          wait_d = wait_q + 8'd1;
          // A word arriving on the last allowed cycle still wins over the timeout.
          if (wait_d == TIMEOUT_W) begin
            err_d   = 1'b1;
            state_d = S_HALTED;
          end
        end
      end
      S_LOAD: begin
        pc_d    = pc_q + 16'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          if (jmp_en) pc_d = jmp_addr;
          state_d = halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: begin
        if (!err_q && !halt) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are computed from the next state so they come straight off flops.
    mem_rd_d = (state_d == S_FETCH);
    iir_d    = (state_d == S_LOAD);
    busy_d   = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      code_q   <= 16'h0000;
      wait_q   <= 8'd0;
      err_q    <= 1'b0;
      iir_q    <= 1'b0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      code_q   <= code_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      iir_q    <= iir_d;
      mem_rd_q <= mem_rd_d;
      busy_q   <= busy_d;
    end
  end

  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign code      = code_q;
  assign iir       = iir_q;
  assign mem_rd    = mem_rd_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-level reference model of fetch/load/exec/halt rules,
// with directed sequences followed by randomized handshake stimulus.
module tb_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_rdy;
  logic [15:0] mem_q;
  logic [15:0] code;
  logic        iir;
  logic        exec_done;
  logic        jmp_en;
  logic [15:0] jmp_addr;
  logic        halt;
  logic [15:0] pc;
  logic        busy;
  logic        err;
  logic [2:0]  dbg_state;

  fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdy(mem_rdy), .mem_q(mem_q), .code(code), .iir(iir),
    .exec_done(exec_done), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .halt(halt),
    .pc(pc), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- program memory ----------------
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h0800;
    if (a == 16'h0001) return 16'h1003;
    return 16'(a * 16'h003B + 16'h7000);
  endfunction

  always_comb mem_q = mem_word(mem_addr);

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 fetching, 2 loading, 3 executing, 4 halted
  int          m_phase;
  logic [15:0] m_pc;
  logic [15:0] m_code;
  int          m_wait;
  logic        m_err;
  logic [15:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic prev_iir;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_pc     = 16'h0000;
    m_code   = 16'h0000;
    m_wait   = 0;
    m_err    = 1'b0;
    prev_iir = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      m_phase = halt ? 4 : 1;
    end else if (m_phase == 1) begin
      if (mem_rdy) begin
        m_code = mem_word(m_pc);
        exp_q.push_back(m_code);
        m_wait  = 0;
        m_phase = 2;
      end else begin
        m_wait++;
        if (m_wait >= TIMEOUT) begin
          m_err   = 1'b1;
          m_phase = 4;
        end
      end
    end else if (m_phase == 2) begin
      m_pc    = m_pc + 16'd1;
      m_phase = 3;
    end else if (m_phase == 3) begin
      if (exec_done) begin
        if (jmp_en) m_pc = jmp_addr;
        m_phase = halt ? 4 : 1;
      end
    end else begin
      if (!m_err && !halt) m_phase = 1;
    end
  endtask

  task automatic check_outputs();
    check_val("mem_rd", 32'(mem_rd), 32'(m_phase == 1));
    check_val("iir", 32'(iir), 32'(m_phase == 2));
    check_val("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 3));
    check_val("err", 32'(err), 32'(m_err));
    check_val("pc", 32'(pc), 32'(m_pc));
    check_val("mem_addr", 32'(mem_addr), 32'(m_pc));
    check_val("code", 32'(code), 32'(m_code));
    if (prev_iir) check_val("iir_single", 32'(iir), 32'd0);
    prev_iir = iir;
    if (m_phase == 2) begin
      if (exp_q.size() == 0) check_val("sb_depth", 32'(exp_q.size()), 32'd1);
      else check_val("sb_code", 32'(code), 32'(exp_q.pop_front()));
    end
  endtask

  // Inputs are already applied; advance model and DUT by one clock, then compare.
  task automatic do_cycle();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_idle();
    mem_rdy = 1'b0; exec_done = 1'b0; jmp_en = 1'b0; jmp_addr = 16'h0000; halt = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int  n_iir, last_iir_cyc, cyc, hold, fetch_cnt;
  logic halt_done, wrap_pending, jump_pending, found;

  initial begin
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs();
    apply_reset();

    // Tied-high handshakes with scripted halt, jump and wrap.
    n_iir = 0; last_iir_cyc = 0; hold = 0;
    halt_done = 1'b0; wrap_pending = 1'b0; jump_pending = 1'b0;
    mem_rdy = 1'b1; exec_done = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      jmp_en = 1'b0;
      if (m_phase == 3 && m_pc == 16'h0005) begin
        jmp_en = 1'b1; jmp_addr = 16'h0040; jump_pending = 1'b1;
      end
      if (m_phase == 3 && m_pc == 16'h0043) begin
        jmp_en = 1'b1; jmp_addr = 16'hFFFF; wrap_pending = 1'b1;
      end
      if (m_phase == 1 && m_pc == 16'h0002 && !halt_done) halt = 1'b1;
      if (m_phase == 4 && halt) begin
        hold++;
        if (hold == 4) begin halt = 1'b0; halt_done = 1'b1; end
      end
      do_cycle();
      if (iir) begin
        if (n_iir == 0) check_val("first_code", 32'(code), 32'h0800);
        if (n_iir == 1) check_val("second_code", 32'(code), 32'h1003);
        if (n_iir == 1 || n_iir == 2) check_val("iir_period", 32'(c - last_iir_cyc), 32'd3);
        last_iir_cyc = c;
        n_iir++;
      end
      if (jump_pending && m_phase == 1) begin
        check_val("jump_target", 32'(mem_addr), 32'h0040);
        jump_pending = 1'b0;
      end
      if (wrap_pending && m_phase == 3) begin
        check_val("wrap_pc", 32'(pc), 32'h0000);
        wrap_pending = 1'b0;
      end
    end

    // Timeout: memory never answers.
    drive_idle();
    apply_reset();
    fetch_cnt = 0;
    for (int c = 0; c < 35; c++) begin
      do_cycle();
      if (mem_rd) fetch_cnt++;
    end
    check_val("timeout_fetch_cycles", 32'(fetch_cnt), 32'd15);
    check_val("timeout_err", 32'(err), 32'd1);
    check_val("timeout_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a LOAD cycle.
    drive_idle();
    apply_reset();
    mem_rdy = 1'b1; exec_done = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      do_cycle();
      if (m_phase == 2 && m_pc != 16'h0000) found = 1'b1;
    end
    check_val("reach_load", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_iir", 32'(iir), 32'd0);
    check_val("arst_mem_rd", 32'(mem_rd), 32'd0);
    check_val("arst_code", 32'(code), 32'd0);
    check_val("arst_pc", 32'(pc), 32'd0);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) do_cycle();

    // Randomized handshakes, branches and halts.
    drive_idle();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      mem_rdy   = ($urandom_range(0, 3) != 0);
      exec_done = ($urandom_range(0, 2) == 0);
      jmp_en    = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: jmp_addr = 16'h0040;
        1: jmp_addr = 16'hFFFF;
        2: jmp_addr = 16'hFFFE;
        default: jmp_addr = 16'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
